// File: rtl/tx_pkt_builder_pkg.sv
// Packet format definitions shared by the transmit builder and receive-side node-info logic.
// Holds type codes, payload lengths, header field layout and the payload ordering table.
package tx_pkt_builder_pkg;

  localparam int unsigned HdrTypeW = 3;
  localparam int unsigned HdrLenW  = 8;
  localparam int unsigned CntW     = 3;

  typedef enum logic [2:0] {
    PktHeartbeat  = 3'b000,
    PktChAnnounce = 3'b001,
    PktJoin       = 3'b010,
    PktData       = 3'b101
  } pkt_type_e;

  localparam logic [HdrLenW-1:0] LenHeartbeat  = 8'd4;
  localparam logic [HdrLenW-1:0] LenChAnnounce = 8'd3;
  localparam logic [HdrLenW-1:0] LenJoin       = 8'd3;
  localparam logic [HdrLenW-1:0] LenData       = 8'd4;

  typedef enum logic [2:0] {
    FldNone,
    FldId,
    FldHops,
    FldQ,
    FldEnergy,
    FldDest,
    FldData
  } pkt_field_e;

  function automatic logic pkt_supported(logic [2:0] t);
    case (t)
      PktHeartbeat, PktChAnnounce, PktJoin, PktData: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  function automatic logic [HdrLenW-1:0] pkt_len(logic [2:0] t);
    case (t)
      PktHeartbeat:  return LenHeartbeat;
      PktChAnnounce: return LenChAnnounce;
      PktJoin:       return LenJoin;
      PktData:       return LenData;
      default:       return '0;
    endcase
  endfunction

  // Payload word order per packet type, indexed by the payload word counter.
  function automatic pkt_field_e pkt_field(logic [2:0] t, logic [CntW-1:0] idx);
    pkt_field_e f;
    f = FldNone;
    case (t)
      PktHeartbeat: begin
        case (idx)
          3'd0:    f = FldId;
          3'd1:    f = FldHops;
          3'd2:    f = FldEnergy;
          3'd3:    f = FldQ;
          default: f = FldNone;
        endcase
      end
      PktChAnnounce: begin
        case (idx)
          3'd0:    f = FldId;
          3'd1:    f = FldQ;
          3'd2:    f = FldEnergy;
          default: f = FldNone;
        endcase
      end
      PktJoin: begin
        case (idx)
          3'd0:    f = FldId;
          3'd1:    f = FldDest;
          3'd2:    f = FldEnergy;
          default: f = FldNone;
        endcase
      end
      PktData: begin
        case (idx)
          3'd0:    f = FldId;
          3'd1:    f = FldDest;
          3'd2:    f = FldHops;
          3'd3:    f = FldData;
          default: f = FldNone;
        endcase
      end
      default: f = FldNone;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/tx_pkt_builder.sv
// Serialises one node packet (header word followed by type-dependent payload words)
// onto a valid/ready word stream; fields are snapshotted when the request is accepted.
module tx_pkt_builder
  import tx_pkt_builder_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  tx_req,
  input  logic [2:0]            tx_type,
  input  logic [WORD_WIDTH-1:0] my_node_id,
  input  logic [WORD_WIDTH-1:0] hops,
  input  logic [WORD_WIDTH-1:0] q_value,
  input  logic [WORD_WIDTH-1:0] energy,
  input  logic [WORD_WIDTH-1:0] dest_id,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic                  tx_ready,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  tx_last,
  output logic                  busy,
  output logic                  tx_done,
  output logic                  tx_err
);

  localparam int unsigned PadW = WORD_WIDTH - HdrTypeW - HdrLenW;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StPayload,
    StDone
  } state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [2:0]            type_q;
  logic [WORD_WIDTH-1:0] id_q;
  logic [WORD_WIDTH-1:0] hops_q;
  logic [WORD_WIDTH-1:0] q_q;
  logic [WORD_WIDTH-1:0] energy_q;
  logic [WORD_WIDTH-1:0] dest_q;
  logic [WORD_WIDTH-1:0] data_q;
  logic                  done_q;
  logic                  err_q;

  logic [HdrLenW-1:0]    cur_len;
  logic                  last_word;
  pkt_field_e            cur_field;

  assign cur_len   = pkt_len(type_q);
  assign cur_field = pkt_field(type_q, cnt_q);
  assign last_word = (state_q == StPayload) && (cnt_q == CntW'(cur_len - 8'd1));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      type_q   <= '0;
      id_q     <= '0;
      hops_q   <= '0;
      q_q      <= '0;
      energy_q <= '0;
      dest_q   <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (tx_req) begin
            if (pkt_supported(tx_type)) begin
              type_q   <= tx_type;
              id_q     <= my_node_id;
              hops_q   <= hops;
              q_q      <= q_value;
              energy_q <= energy;
              dest_q   <= dest_id;
              data_q   <= data_in;
              cnt_q    <= '0;
              state_q  <= StHdr;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StHdr: begin
          if (tx_ready) state_q <= StPayload;
        end
        StPayload: begin
          if (tx_ready) begin
            if (last_word) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Word mux reads only registered state, so tx_data holds while the sink stalls.
  always_comb begin
    tx_data = '0;
    case (state_q)
      StHdr: tx_data = {type_q, {PadW{1'b0}}, cur_len};
      StPayload: begin
        unique case (cur_field)
          FldId:     tx_data = id_q;
          FldHops:   tx_data = hops_q;
          FldQ:      tx_data = q_q;
          FldEnergy: tx_data = energy_q;
          FldDest:   tx_data = dest_q;
          FldData:   tx_data = data_q;
          FldNone:   tx_data = '0;
        endcase
      end
      default: tx_data = '0;
    endcase
  end

  assign tx_valid = (state_q == StHdr) || (state_q == StPayload);
  assign tx_last  = last_word;
  assign busy     = (state_q != StIdle);
  assign tx_done  = done_q;
  assign tx_err   = err_q;

endmodule

// File: tb/tb_tx_pkt_builder.sv
// Directed bench for tx_pkt_builder: hand-computed word sequences, stalls, errors,
// mid-packet reset and back-to-back requests.
module tb_tx_pkt_builder;

  logic        clk;
  logic        nrst;
  logic        tx_req;
  logic [2:0]  tx_type;
  logic [15:0] my_node_id;
  logic [15:0] hops;
  logic [15:0] q_value;
  logic [15:0] energy;
  logic [15:0] dest_id;
  logic [15:0] data_in;
  logic        tx_ready;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_last;
  logic        busy;
  logic        tx_done;
  logic        tx_err;

  int n_checks;
  int n_fail;

  logic [15:0] w [5];

  tx_pkt_builder #(
    .WORD_WIDTH(16)
  ) u_dut (
    .clk       (clk),
    .nrst      (nrst),
    .tx_req    (tx_req),
    .tx_type   (tx_type),
    .my_node_id(my_node_id),
    .hops      (hops),
    .q_value   (q_value),
    .energy    (energy),
    .dest_id   (dest_id),
    .data_in   (data_in),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .busy      (busy),
    .tx_done   (tx_done),
    .tx_err    (tx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_data"}, 32'(tx_data), 32'h0);
    check_eq({tag, "_valid"}, 32'(tx_valid), 32'h0);
    check_eq({tag, "_last"}, 32'(tx_last), 32'h0);
    check_eq({tag, "_busy"}, 32'(busy), 32'h0);
    check_eq({tag, "_done"}, 32'(tx_done), 32'h0);
    check_eq({tag, "_err"}, 32'(tx_err), 32'h0);
  endtask

  // Called on a negedge; the accept happens at the following posedge.
  task automatic start_pkt(input logic [2:0] t, input logic [15:0] id, input logic [15:0] hp,
                           input logic [15:0] q, input logic [15:0] en, input logic [15:0] ds,
                           input logic [15:0] dt);
    tx_type    = t;
    my_node_id = id;
    hops       = hp;
    q_value    = q;
    energy     = en;
    dest_id    = ds;
    data_in    = dt;
    tx_req     = 1'b1;
    @(negedge clk);
    tx_req     = 1'b0;
  endtask

  // Starts on the negedge where the header should be presented.
  task automatic drain(input string tag, input logic [15:0] exp [5], input int n,
                       input bit toggle, input bit poke, input bit hold);
    int k;
    int j;
    k = 0;
    j = 0;
    while (k < n && j < 40) begin
      tx_ready = toggle ? (j % 2 == 0) : 1'b1;
      if (poke && j == 2) begin
        data_in = 16'hFFFF;
        tx_req  = 1'b1;
      end
      check_eq({tag, "_valid"}, 32'(tx_valid), 32'h1);
      check_eq({tag, "_data"}, 32'(tx_data), 32'(exp[k]));
      check_eq({tag, "_last"}, 32'(tx_last), 32'(k == n - 1));
      check_eq({tag, "_busy"}, 32'(busy), 32'h1);
      if (tx_ready) k++;
      j++;
      @(negedge clk);
    end
    check_eq({tag, "_word_count"}, 32'(k), 32'(n));
    if (!hold) tx_req = 1'b0;
    check_eq({tag, "_done_pulse"}, 32'(tx_done), 32'h1);
    check_eq({tag, "_done_valid"}, 32'(tx_valid), 32'h0);
    @(negedge clk);
    check_eq({tag, "_done_clear"}, 32'(tx_done), 32'h0);
    check_eq({tag, "_idle_busy"}, 32'(busy), 32'h0);
    check_eq({tag, "_idle_valid"}, 32'(tx_valid), 32'h0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    nrst       = 1'b0;
    tx_req     = 1'b0;
    tx_type    = 3'b000;
    my_node_id = '0;
    hops       = '0;
    q_value    = '0;
    energy     = '0;
    dest_id    = '0;
    data_in    = '0;
    tx_ready   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    nrst = 1'b1;
    @(negedge clk);

    // Heartbeat, sink always ready.
    tx_ready = 1'b1;
    start_pkt(3'b000, 16'h000C, 16'h0003, 16'h0050, 16'h1234, 16'h0000, 16'h0000);
    w = '{16'h0004, 16'h000C, 16'h0003, 16'h1234, 16'h0050};
    drain("hb", w, 5, 1'b0, 1'b0, 1'b0);

    // CH announce with a stalling sink.
    start_pkt(3'b001, 16'h000C, 16'h0003, 16'h0050, 16'h1234, 16'h0000, 16'h0000);
    w = '{16'h2003, 16'h000C, 16'h0050, 16'h1234, 16'h0000};
    drain("cha", w, 4, 1'b1, 1'b0, 1'b0);

    // Unsupported type.
    tx_type = 3'b111;
    tx_req  = 1'b1;
    @(negedge clk);
    tx_req = 1'b0;
    check_eq("err_pulse", 32'(tx_err), 32'h1);
    check_eq("err_valid", 32'(tx_valid), 32'h0);
    check_eq("err_busy", 32'(busy), 32'h0);
    @(negedge clk);
    check_eq("err_clear", 32'(tx_err), 32'h0);
    check_eq("err_busy2", 32'(busy), 32'h0);

    // Data packet; data_in changes and tx_req rises mid-payload.
    start_pkt(3'b101, 16'h000C, 16'h0003, 16'h0050, 16'h1234, 16'h0009, 16'hABCD);
    w = '{16'hA004, 16'h000C, 16'h0009, 16'h0003, 16'hABCD};
    drain("data", w, 5, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("data_no_requeue_busy", 32'(busy), 32'h0);
    check_eq("data_single_done", 32'(tx_done), 32'h0);

    // Join packet aborted by reset after two payload words.
    tx_ready = 1'b1;
    start_pkt(3'b010, 16'h000C, 16'h0003, 16'h0050, 16'h1234, 16'h0007, 16'h0000);
    check_eq("abort_hdr", 32'(tx_data), 32'h4003);
    @(negedge clk);
    check_eq("abort_p0", 32'(tx_data), 32'h000C);
    @(negedge clk);
    check_eq("abort_p1", 32'(tx_data), 32'h0007);
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    nrst = 1'b1;
    @(negedge clk);
    check_eq("abort_no_words", 32'(tx_valid), 32'h0);
    check_eq("abort_no_done", 32'(tx_done), 32'h0);
    start_pkt(3'b010, 16'h000C, 16'h0003, 16'h0050, 16'h1234, 16'h0007, 16'h0000);
    w = '{16'h4003, 16'h000C, 16'h0007, 16'h1234, 16'h0000};
    drain("join", w, 4, 1'b0, 1'b0, 1'b0);

    // Back-to-back with tx_req held: accept in the IDLE cycle after DONE.
    start_pkt(3'b001, 16'h0011, 16'h0001, 16'h0022, 16'h0033, 16'h0000, 16'h0000);
    tx_req = 1'b1;
    w = '{16'h2003, 16'h0011, 16'h0022, 16'h0033, 16'h0000};
    drain("b2b1", w, 4, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    w = '{16'h2003, 16'h0011, 16'h0022, 16'h0033, 16'h0000};
    drain("b2b2", w, 4, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("b2b_end_busy", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
